// File: rtl/fifo_drain_fsm.sv
// Read-side FIFO drain controller: hysteresis start, bounded bursts, registered output.
// Define CHECK_PATTERN_EN to build the fixed-pattern checker behind err_count.
module fifo_drain_fsm #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 4,
   parameter int START_LEVEL = 5,
   parameter int STOP_LEVEL  = 2,
   parameter int MAX_BURST   = 4,
   parameter logic [DATA_WIDTH-1:0] EXPECTED = 8'hAA
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   rd_en,
   input  logic [DATA_WIDTH-1:0]  fifo_data,
   input  logic [COUNT_WIDTH-1:0] fifo_words,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   output logic [15:0]            rd_count,
   output logic [7:0]             err_count
);

   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [COUNT_WIDTH-1:0] START_W = COUNT_WIDTH'(START_LEVEL);
   localparam logic [COUNT_WIDTH-1:0] STOP_W  = COUNT_WIDTH'(STOP_LEVEL);
   localparam logic [BW-1:0]          LAST    = BW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t        state;
   logic [BW-1:0] burst_cnt;
   logic          rd_q;

   // Occupancy above STOP_LEVEL guarantees at least one word is present.
   assign rd_en = rst_n && (state == READ) && (fifo_words > STOP_W);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         burst_cnt <= '0;
         rd_q      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         rd_count  <= '0;
      end else begin
         rd_q <= rd_en;
         if (rd_q) begin
            out_data  <= fifo_data;
            out_valid <= 1'b1;
            rd_count  <= rd_count + 16'd1;
         end else begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               burst_cnt <= '0;
               if (fifo_words >= START_W)
                  state <= READ;
            end
            READ: begin
               if (rd_en)
                  burst_cnt <= burst_cnt + 1'b1;
               if (!rd_en || (burst_cnt == LAST))
                  state <= SETTLE;
            end
            SETTLE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CHECK_PATTERN_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         err_count <= '0;
      else if (rd_q && (fifo_data != EXPECTED) && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`else
   logic [DATA_WIDTH-1:0] unused_pattern;
   assign unused_pattern = EXPECTED;
   assign err_count      = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// Directed bench for fifo_drain_fsm: two instances (burst cap 4 and 16)
// each fed by a small FIFO occupancy/data model.
module tb_fifo_drain_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  words0, words1;
   logic [7:0]  fdata0, fdata1;
   logic        rd_en0, rd_en1;
   logic [7:0]  out_data0, out_data1;
   logic        out_valid0, out_valid1;
   logic [15:0] rd_count0, rd_count1;
   logic [7:0]  err_count0, err_count1;

   logic [7:0] mem [0:15];
   logic [7:0] cap0 [0:7];
   int p0, p1, cyc;
   int rds0, rds1, ovs0, ovs1;
   int first_rd0, first_ov0, last_ov0;
   int ov_before;
   int checks, errors;

   fifo_drain_fsm dut0 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en0),
      .fifo_data(fdata0), .fifo_words(words0),
      .out_data(out_data0), .out_valid(out_valid0),
      .rd_count(rd_count0), .err_count(err_count0)
   );

   fifo_drain_fsm #(.MAX_BURST(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en1),
      .fifo_data(fdata1), .fifo_words(words1),
      .out_data(out_data1), .out_valid(out_valid1),
      .rd_count(rd_count1), .err_count(err_count1)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rds0 = 0; rds1 = 0; ovs0 = 0; ovs1 = 0; cyc = 0;
      first_rd0 = -1; first_ov0 = -1; last_ov0 = -1;
   endtask

   // One clock: FIFO model pops on the pre-edge rd_en, data valid after edge.
   task automatic tick();
      logic r0, r1;
      #1;
      r0 = rd_en0;
      r1 = rd_en1;
      @(posedge clk);
      #1;
      cyc++;
      if (r0 === 1'b1) begin
         fdata0 = mem[p0]; p0++; words0 = words0 - 4'd1; rds0++;
      end
      if (r1 === 1'b1) begin
         fdata1 = mem[p1]; p1++; words1 = words1 - 4'd1; rds1++;
      end
      if (rd_en0 === 1'b1 && first_rd0 < 0) first_rd0 = cyc;
      if (out_valid0 === 1'b1) begin
         if (ovs0 < 8) cap0[ovs0] = out_data0;
         if (first_ov0 < 0) first_ov0 = cyc;
         last_ov0 = cyc;
         ovs0++;
      end
      if (out_valid1 === 1'b1) ovs1++;
   endtask

   task automatic do_reset(logic [3:0] w0, logic [3:0] w1);
      rst_n = 1'b0;
      tick();
      tick();
      words0 = w0; words1 = w1;
      p0 = 0; p1 = 0;
      clr();
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0; errors = 0;
      words0 = 4'd8; words1 = 4'd8;
      fdata0 = 8'h00; fdata1 = 8'h00;
      p0 = 0; p1 = 0;
      clr();
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      mem[0] = 8'hAA; mem[1] = 8'h55; mem[2] = 8'hAA; mem[3] = 8'hAA;
      for (int i = 0; i < 8; i++) cap0[i] = 8'h00;

      // reset held with a full FIFO
      repeat (3) tick();
      check("rst_rd_en", rd_en0, 0);
      check("rst_rd_en_b", rd_en1, 0);
      check("rst_out_valid", out_valid0, 0);
      check("rst_rd_count", rd_count0, 0);
      check("rst_err_count", err_count0, 0);
      check("rst_no_reads", rds0, 0);

      // threshold: 4 words never starts a burst
      words0 = 4'd4; words1 = 4'd0;
      rst_n = 1'b1;
      clr();
      repeat (20) tick();
      check("thr_never", first_rd0, -1);
      check("thr_reads4", rds0, 0);
      words0 = 4'd5;
      #1;
      check("thr_pre", rd_en0, 0);
      tick();
      check("thr_rd_en", rd_en0, 1);
      repeat (10) tick();
      check("thr_reads5", rds0, 3);
      check("thr_words", words0, 2);

      // burst cap with 8 words
      do_reset(4'd8, 4'd0);
      #1;
      check("cap_rel_rd_en", rd_en0, 0);
      repeat (20) tick();
      check("cap_first_rd", first_rd0, 1);
      check("cap_first_ov", first_ov0, 3);
      check("cap_last_ov", last_ov0, 6);
      check("cap_reads", rds0, 4);
      check("cap_ovs", ovs0, 4);
      check("cap_words", words0, 4);
      check("cap_rd_count", rd_count0, 4);

      // stop level with MAX_BURST=16 and 6 words
      do_reset(4'd0, 4'd6);
      repeat (20) tick();
      check("stop_reads", rds1, 4);
      check("stop_words", words1, 2);
      check("stop_rd_count", rd_count1, 4);
      check("stop_ovs", ovs1, 4);
      check("stop_other_idle", rds0, 0);

      // pattern AA,55,AA,AA
      do_reset(4'd8, 4'd0);
      repeat (20) tick();
      check("pat_d0", cap0[0], 8'hAA);
      check("pat_d1", cap0[1], 8'h55);
      check("pat_d2", cap0[2], 8'hAA);
      check("pat_d3", cap0[3], 8'hAA);
      check("pat_rd_count", rd_count0, 4);
`ifdef CHECK_PATTERN_EN
      check("pat_err_count", err_count0, 1);
`else
      check("pat_err_count", err_count0, 0);
`endif

      // reset in the cycle after the second rd_en
      do_reset(4'd8, 4'd0);
      tick();
      tick();
      tick();
      check("mid_pre", rd_en0, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rd_en", rd_en0, 0);
      ov_before = ovs0;
      tick();
      tick();
      check("mid_no_ov", ovs0, ov_before);
      check("mid_reads", rds0, 2);
      check("mid_rd_count", rd_count0, 0);
      check("mid_err_count", err_count0, 0);
      words0 = 4'd8; p0 = 0;
      clr();
      rst_n = 1'b1;
      repeat (20) tick();
      check("mid_new_reads", rds0, 4);
      check("mid_new_ovs", ovs0, 4);
      check("mid_new_rd_count", rd_count0, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
